// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time/alarm setting controller: FSM states,
// edit_field encodings, BCD limits and the BCD increment helpers.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT_HR  = 2'd1,
    ST_EDIT_MIN = 2'd2,
    ST_LOAD     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'b00,
    FIELD_HR   = 2'b01,
    FIELD_MIN  = 2'b10
  } field_e;

  localparam logic [7:0] HR_LIMIT  = 8'd23;
  localparam logic [7:0] MIN_LIMIT = 8'd59;

  // Bit positions of the buttons inside the packed button vectors.
  localparam int BTN_INC  = 0;
  localparam int BTN_OK   = 1;
  localparam int BTN_MODE = 2;

  // Hours step 00..23; anything captured at or above the limit wraps to 00.
  function automatic logic [5:0] inc_hours(input logic [1:0] tens, input logic [3:0] ones);
    logic [7:0] val;
    val = {6'd0, tens} * 8'd10 + {4'd0, ones};
    if (val >= HR_LIMIT)   return 6'd0;
    else if (ones >= 4'd9) return {tens + 2'd1, 4'd0};
    else                   return {tens, ones + 4'd1};
  endfunction

  // Minutes step 00..59 with no carry out.
  function automatic logic [7:0] inc_minutes(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] val;
    val = {4'd0, tens} * 8'd10 + {4'd0, ones};
    if (val >= MIN_LIMIT)  return 8'd0;
    else if (ones >= 4'd9) return {tens + 4'd1, 4'd0};
    else                   return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button debouncer: the output level follows the input only after the input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          level_q;

  // Count cycles of disagreement; accept the new level when the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (din_i == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= din_i;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign dout_o = level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller. Buttons are synchronised, edge-detected and
// drive an edit FSM (hours, then minutes) that ends in a load strobe to the
// clock. Define SET_DEBOUNCE_EN to insert a debouncer on each button.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 600,
  parameter int unsigned LD_CYCLES       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       tgt_alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       busy,
  output logic [1:0] edit_field
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LD_W = $clog2(LD_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(LD_CYCLES - 1);

  logic [2:0] btn_raw, sync1_q, sync2_q, btn_lvl, prev_q, evt;

  assign btn_raw = {btn_mode, btn_ok, btn_inc};

  // Two-flop synchronisers for all three buttons.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SET_DEBOUNCE_EN
  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (reset),
      .din_i  (sync2_q[i]),
      .dout_o (btn_lvl[i])
    );
  end
`else
  assign btn_lvl = sync2_q;
`endif

  // Previous level for single-cycle rising-edge events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= btn_lvl;
  end

  assign evt = btn_lvl & ~prev_q;

  state_e          state_q;
  field_e          field_q;
  logic [1:0]      hr1_q;
  logic [3:0]      hr0_q, mn1_q, mn0_q;
  logic            tgt_q, busy_q, ld_time_q, ld_alarm_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [LD_W-1:0] ld_cnt_q;
  logic [5:0]      hr_next;
  logic [7:0]      mn_next;

  assign hr_next = inc_hours(hr1_q, hr0_q);
  assign mn_next = inc_minutes(mn1_q, mn0_q);

  // Edit FSM with registered outputs; priority mode > ok > inc > timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      field_q    <= FIELD_NONE;
      // NOTE: the edit register is reset because it drives the outputs and must read 00:00.
      hr1_q      <= '0;
      hr0_q      <= '0;
      mn1_q      <= '0;
      mn0_q      <= '0;
      tgt_q      <= 1'b0;
      busy_q     <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      to_cnt_q   <= '0;
      ld_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt[BTN_MODE]) begin
            hr1_q    <= cur_H1;
            hr0_q    <= cur_H0;
            mn1_q    <= cur_M1;
            mn0_q    <= cur_M0;
            tgt_q    <= tgt_alarm;
            state_q  <= ST_EDIT_HR;
            field_q  <= FIELD_HR;
            busy_q   <= 1'b1;
            to_cnt_q <= '0;
          end
        end
        ST_EDIT_HR, ST_EDIT_MIN: begin
          if (evt[BTN_MODE] || (!evt[BTN_OK] && !evt[BTN_INC] && to_cnt_q == TO_LAST)) begin
            state_q <= ST_IDLE;
            field_q <= FIELD_NONE;
            busy_q  <= 1'b0;
          end else if (evt[BTN_OK]) begin
            to_cnt_q <= '0;
            if (state_q == ST_EDIT_HR) begin
              state_q <= ST_EDIT_MIN;
              field_q <= FIELD_MIN;
            end else begin
              state_q    <= ST_LOAD;
              field_q    <= FIELD_NONE;
              ld_cnt_q   <= '0;
              ld_time_q  <= ~tgt_q;
              ld_alarm_q <= tgt_q;
            end
          end else if (evt[BTN_INC]) begin
            to_cnt_q <= '0;
            if (state_q == ST_EDIT_HR) {hr1_q, hr0_q} <= hr_next;
            else                       {mn1_q, mn0_q} <= mn_next;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_LOAD: begin
          if (ld_cnt_q == LD_LAST) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
          end else begin
            ld_cnt_q <= ld_cnt_q + LD_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          field_q    <= FIELD_NONE;
          busy_q     <= 1'b0;
          ld_time_q  <= 1'b0;
          ld_alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign H_in1      = hr1_q;
  assign H_in0      = hr0_q;
  assign M_in1      = mn1_q;
  assign M_in0      = mn0_q;
  assign LD_time    = ld_time_q;
  assign LD_alarm   = ld_alarm_q;
  assign busy       = busy_q;
  assign edit_field = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl (default build, no debounce).
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0, tgt_alarm = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, busy;
  logic [1:0] edit_field;
  logic [13:0] shown;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] B_MODE = 3'b100;
  localparam logic [2:0] B_OK   = 3'b010;
  localparam logic [2:0] B_INC  = 3'b001;

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_ok     (btn_ok),
    .tgt_alarm  (tgt_alarm),
    .cur_H1     (cur_H1),
    .cur_H0     (cur_H0),
    .cur_M1     (cur_M1),
    .cur_M0     (cur_M0),
    .H_in1      (H_in1),
    .H_in0      (H_in0),
    .M_in1      (M_in1),
    .M_in0      (M_in0),
    .LD_time    (LD_time),
    .LD_alarm   (LD_alarm),
    .busy       (busy),
    .edit_field (edit_field)
  );

  assign shown = {H_in1, H_in0, M_in1, M_in0};

  function automatic logic [13:0] hm(input int h1, input int h0, input int m1, input int m0);
    return {2'(h1), 4'(h0), 4'(m1), 4'(m0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press; returns one sample after the FSM has acted on it.
  task automatic press(input logic [2:0] b);
    {btn_mode, btn_ok, btn_inc} = b;
    tick();
    {btn_mode, btn_ok, btn_inc} = 3'b000;
    tick();
    tick();
  endtask

  task automatic seed(input int h1, input int h0, input int m1, input int m0);
    cur_H1 = 2'(h1); cur_H0 = 4'(h0); cur_M1 = 4'(m1); cur_M0 = 4'(m0);
  endtask

  // Collect strobe statistics over the next few cycles.
  task automatic watch_strobe(input logic [13:0] exp, output int nt, output int na, output int bad);
    nt = 0; na = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (LD_time === 1'b1) nt++;
      if (LD_alarm === 1'b1) na++;
      if ((LD_time === 1'b1 || LD_alarm === 1'b1) && shown !== exp) bad++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({LD_time, LD_alarm, busy, edit_field} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b, want 00000", {LD_time, LD_alarm, busy, edit_field});
      n_fail++;
    end
    n_checks++;
    if (shown !== 14'h0) begin
      $display("FAIL reset_value: got %h, want %h", shown, 14'h0);
      n_fail++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_time();
    int nt, na, bad;
    seed(1, 0, 1, 9);
    tgt_alarm = 1'b0;
    press(B_MODE);
    n_checks++;
    if ({busy, edit_field} !== 3'b101 || shown !== hm(1, 0, 1, 9)) begin
      $display("FAIL time_enter: got busy/field %b val %h, want 101 %h", {busy, edit_field}, shown, hm(1, 0, 1, 9));
      n_fail++;
    end
    press(B_INC);
    n_checks++;
    if (shown !== hm(1, 1, 1, 9)) begin
      $display("FAIL time_inc_hr: got %h, want %h", shown, hm(1, 1, 1, 9));
      n_fail++;
    end
    press(B_OK);
    n_checks++;
    if (edit_field !== 2'b10) begin
      $display("FAIL time_field_min: got %b, want 10", edit_field);
      n_fail++;
    end
    press(B_INC);
    n_checks++;
    if (shown !== hm(1, 1, 2, 0)) begin
      $display("FAIL time_inc_min: got %h, want %h", shown, hm(1, 1, 2, 0));
      n_fail++;
    end
    press(B_OK);
    watch_strobe(hm(1, 1, 2, 0), nt, na, bad);
    n_checks++;
    if (nt !== 2 || na !== 0 || bad !== 0) begin
      $display("FAIL time_strobe: got time=%0d alarm=%0d badval=%0d, want 2 0 0", nt, na, bad);
      n_fail++;
    end
    n_checks++;
    if ({busy, edit_field} !== 3'b000 || shown !== hm(1, 1, 2, 0)) begin
      $display("FAIL time_after: got busy/field %b val %h, want 000 %h", {busy, edit_field}, shown, hm(1, 1, 2, 0));
      n_fail++;
    end
  endtask

  task automatic test_load_alarm();
    int nt, na, bad;
    seed(2, 3, 5, 9);
    tgt_alarm = 1'b1;
    press(B_MODE);
    tgt_alarm = 1'b0;
    press(B_INC);
    n_checks++;
    if (shown !== hm(0, 0, 5, 9)) begin
      $display("FAIL alarm_hr_wrap: got %h, want %h", shown, hm(0, 0, 5, 9));
      n_fail++;
    end
    press(B_OK);
    press(B_INC);
    n_checks++;
    if (shown !== hm(0, 0, 0, 0)) begin
      $display("FAIL alarm_min_wrap: got %h, want %h", shown, hm(0, 0, 0, 0));
      n_fail++;
    end
    press(B_OK);
    watch_strobe(hm(0, 0, 0, 0), nt, na, bad);
    n_checks++;
    if (nt !== 0 || na !== 2 || bad !== 0) begin
      $display("FAIL alarm_strobe: got time=%0d alarm=%0d badval=%0d, want 0 2 0", nt, na, bad);
      n_fail++;
    end
  endtask

  task automatic test_hour_steps();
    int seeds_h1[4] = '{0, 1, 2, 2};
    int seeds_h0[4] = '{9, 9, 5, 2};
    int exp_h1[4]   = '{1, 2, 0, 2};
    int exp_h0[4]   = '{0, 0, 0, 3};
    for (int i = 0; i < 4; i++) begin
      seed(seeds_h1[i], seeds_h0[i], 3, 3);
      press(B_MODE);
      press(B_INC);
      n_checks++;
      if (shown !== hm(exp_h1[i], exp_h0[i], 3, 3)) begin
        $display("FAIL hour_step_%0d: got %h, want %h", i, shown, hm(exp_h1[i], exp_h0[i], 3, 3));
        n_fail++;
      end
      press(B_MODE);
    end
  endtask

  task automatic test_cancel();
    seed(0, 9, 0, 5);
    press(B_MODE);
    press(B_INC);
    press(B_MODE);
    n_checks++;
    if ({busy, edit_field, LD_time, LD_alarm} !== 5'b0 || shown !== hm(1, 0, 0, 5)) begin
      $display("FAIL cancel: got ctrl %b val %h, want 00000 %h", {busy, edit_field, LD_time, LD_alarm}, shown, hm(1, 0, 0, 5));
      n_fail++;
    end
    press(B_INC);
    press(B_OK);
    n_checks++;
    if (busy !== 1'b0 || shown !== hm(1, 0, 0, 5)) begin
      $display("FAIL idle_ignore: got busy %b val %h, want 0 %h", busy, shown, hm(1, 0, 0, 5));
      n_fail++;
    end
  endtask

  task automatic test_priority();
    seed(1, 4, 3, 0);
    press(B_MODE);
    press(B_OK | B_INC);
    n_checks++;
    if (edit_field !== 2'b10 || shown !== hm(1, 4, 3, 0)) begin
      $display("FAIL ok_over_inc: got field %b val %h, want 10 %h", edit_field, shown, hm(1, 4, 3, 0));
      n_fail++;
    end
    press(B_INC);
    press(B_MODE | B_OK | B_INC);
    n_checks++;
    if ({busy, LD_time, LD_alarm} !== 3'b000 || shown !== hm(1, 4, 3, 1)) begin
      $display("FAIL mode_first: got ctrl %b val %h, want 000 %h", {busy, LD_time, LD_alarm}, shown, hm(1, 4, 3, 1));
      n_fail++;
    end
  endtask

  task automatic run_timeout(input bit inject, output int n, output bit seen_ld);
    n = 0;
    seen_ld = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
      if (LD_time === 1'b1 || LD_alarm === 1'b1) seen_ld = 1'b1;
      if (inject && n == 597) btn_inc = 1'b1;
      if (inject && n == 598) btn_inc = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    seed(0, 5, 0, 0);
    press(B_MODE);
    run_timeout(1'b0, n, seen);
    n_checks++;
    if (n !== 600 || seen !== 1'b0) begin
      $display("FAIL timeout_plain: got %0d cycles strobe=%0d, want 600 0", n, seen);
      n_fail++;
    end
    press(B_MODE);
    run_timeout(1'b1, n, seen);
    n_checks++;
    if (n !== 1200 || seen !== 1'b0 || shown !== hm(0, 6, 0, 0)) begin
      $display("FAIL timeout_restart: got %0d cycles strobe=%0d val %h, want 1200 0 %h", n, seen, shown, hm(0, 6, 0, 0));
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_strobe();
    seed(1, 0, 1, 9);
    tgt_alarm = 1'b0;
    press(B_MODE);
    press(B_INC);
    press(B_OK);
    press(B_INC);
    press(B_OK);
    n_checks++;
    if (LD_time !== 1'b1) begin
      $display("FAIL strobe_active: got %b, want 1", LD_time);
      n_fail++;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({LD_time, LD_alarm, busy, edit_field} !== 5'b0 || shown !== 14'h0) begin
      $display("FAIL reset_mid_strobe: got ctrl %b val %h, want 00000 0000", {LD_time, LD_alarm, busy, edit_field}, shown);
      n_fail++;
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_time();
    test_load_alarm();
    test_hour_steps();
    test_cancel();
    test_priority();
    test_timeout();
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
